// File: rtl/pipelined_cache_miss_ctrl.sv
// Miss handler for the 2-way pipelined cache: answers hits, runs
// write-back and fill to pmem, stalls upstream, counts hits/misses.
module pipelined_cache_miss_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  input  logic             hit_i,
  input  logic             hit1_i,
  input  logic             lru_i,
  input  logic             dirty_i,
  input  logic             mem_write_i,
  input  logic [31:0]      address_i,
  input  logic [23:0]      victim_tag_i,
  input  logic [255:0]     victim_data_i,
  input  logic             pmem_resp_i,
  input  logic [255:0]     pmem_rdata_i,
  output logic             pmem_read_o,
  output logic             pmem_write_o,
  output logic [31:0]      pmem_address_o,
  output logic [255:0]     pmem_wdata_o,
  output logic             stall_o,
  output logic             mem_resp_o,
  output logic [1:0]       fill_we_o,
  output logic [255:0]     fill_data_o,
  output logic             valid_set_o,
  output logic             dirty_clr_o,
  output logic             dirty_set_o,
  output logic             lru_update_o,
  output logic             lru_way_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o
);

  typedef enum logic [1:0] {
    IDLE, WB, FILL, REPLAY
  } state_e;

  state_e             state_q, state_d;
  logic               way_q, way_d;
  logic [23:0]        vtag_q, vtag_d;
  logic [255:0]       vdata_q, vdata_d;
  logic [31:0]        laddr_q, laddr_d;
  logic               replay_q, replay_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= replay_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Captured miss context needs no reset; it is always written before use.
  always_ff @(posedge clk) begin
    way_q   <= way_d;
    vtag_q  <= vtag_d;
    vdata_q <= vdata_d;
    laddr_q <= laddr_d;
  end

  always_comb begin
    state_d        = state_q;
    way_d          = way_q;
    vtag_d         = vtag_q;
    vdata_d        = vdata_q;
    laddr_d        = laddr_q;
    replay_d       = 1'b0;
    hit_d          = hit_q;
    miss_d         = miss_q;
    pmem_read_o    = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    pmem_wdata_o   = '0;
    stall_o        = 1'b0;
    mem_resp_o     = 1'b0;
    fill_we_o      = 2'b00;
    fill_data_o    = '0;
    valid_set_o    = 1'b0;
    dirty_clr_o    = 1'b0;
    dirty_set_o    = 1'b0;
    lru_update_o   = 1'b0;
    lru_way_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && hit_i) begin
          mem_resp_o   = 1'b1;
          lru_update_o = 1'b1;
          lru_way_o    = ~hit1_i;
          dirty_set_o  = mem_write_i;
          // The replayed lookup of a miss is not a first-pass hit.
          if (!replay_q && hit_q != '1)
            hit_d = hit_q + 1'b1;
        end else if (req_valid_i) begin
          stall_o = 1'b1;
          if (miss_q != '1)
            miss_d = miss_q + 1'b1;
          way_d   = lru_i;
          vtag_d  = victim_tag_i;
          vdata_d = victim_data_i;
          laddr_d = {address_i[31:5], 5'b0};
          state_d = dirty_i ? WB : FILL;
        end
      end
      WB: begin
        stall_o        = 1'b1;
        pmem_write_o   = 1'b1;
        pmem_address_o = {vtag_q, laddr_q[7:5], 5'b0};
        pmem_wdata_o   = vdata_q;
        if (pmem_resp_i)
          state_d = FILL;
      end
      FILL: begin
        stall_o        = 1'b1;
        pmem_read_o    = 1'b1;
        pmem_address_o = laddr_q;
        if (pmem_resp_i) begin
          fill_we_o[way_q] = 1'b1;
          fill_data_o      = pmem_rdata_i;
          valid_set_o      = 1'b1;
          dirty_clr_o      = 1'b1;
          state_d          = REPLAY;
        end
      end
      REPLAY: begin
        stall_o  = 1'b1;
        replay_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;

endmodule
